// File: rtl/mem_access_unit.sv
// Data-memory access unit: one word/byte request per transaction, bus handshake with timeout.
// Optional build macro MEM_MISALIGN_TRAP_EN traps misaligned word accesses without a bus cycle.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic        stype,
  input  logic        ltype,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        rvalid,
  output logic [31:0] rdata_out,
  output logic        err,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e     state_q, state_d;
  logic [7:0] tmo_cnt_q;
  logic [1:0] lane_q;
  logic       ltype_q;
  logic       req;
  logic       misalign;
  logic       timeout;
  logic [7:0] rd_byte;

  assign req = req_rd | req_wr;

`ifdef MEM_MISALIGN_TRAP_EN
  // Word access is sw for writes, lw for reads; the write wins when both are requested.
  assign misalign = (addr[1:0] != 2'b00) && (req_wr ? !stype : !ltype);
`else
  assign misalign = 1'b0;
`endif

  // Fires on the last allowed ACCESS cycle; a concurrent mem_ready wins.
  assign timeout = !mem_ready && (tmo_cnt_q == TimeoutLast);

  always_comb begin
    rd_byte = mem_rdata[7:0];
    unique case (lane_q)
      2'd0: rd_byte = mem_rdata[7:0];
      2'd1: rd_byte = mem_rdata[15:8];
      2'd2: rd_byte = mem_rdata[23:16];
      2'd3: rd_byte = mem_rdata[31:24];
      default: rd_byte = mem_rdata[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = misalign ? StResp : StAccess;
        end
      end
      StAccess: begin
        if (mem_ready || timeout) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q != StIdle);
    mem_valid = (state_q == StAccess);
    rvalid    = (state_q == StResp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= 8'd0;
      lane_q    <= 2'd0;
      ltype_q   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'd0;
      rdata_out <= 32'd0;
      err       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            mem_addr  <= {addr[31:2], 2'b00};
            mem_we    <= req_wr && !misalign;
            lane_q    <= addr[1:0];
            ltype_q   <= ltype;
            tmo_cnt_q <= 8'd0;
            if (req_wr && stype) begin
              mem_be    <= 4'b0001 << addr[1:0];
              mem_wdata <= {4{wdata[7:0]}};
            end else begin
              mem_be    <= 4'hF;
              mem_wdata <= wdata;
            end
            if (misalign) begin
              err       <= 1'b1;
              rdata_out <= 32'd0;
            end
          end
        end
        StAccess: begin
          if (mem_ready) begin
            err <= 1'b0;
            if (!mem_we) begin
              rdata_out <= ltype_q ? {24'd0, rd_byte} : mem_rdata;
            end
          end else if (timeout) begin
            err       <= 1'b1;
            rdata_out <= 32'd0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        StResp: begin
          err <= 1'b0;
        end
        default: begin
          err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases then randomized transactions
// checked against a transaction-level reference model.
module tb_mem_access_unit;

  localparam int unsigned T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_rd;
  logic        req_wr;
  logic        stype;
  logic        ltype;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        rvalid;
  logic [31:0] rdata_out;
  logic        err;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int          n_total = 0;
  int          n_pass = 0;
  logic [31:0] exp_rdata = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_rd    (req_rd),
    .req_wr    (req_wr),
    .stype     (stype),
    .ltype     (ltype),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .rvalid    (rvalid),
    .rdata_out (rdata_out),
    .err       (err),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a falling edge; drives the request, plays the bus for `waits` wait cycles
  // (waits >= T means ready never comes) and checks every cycle up to the return to idle.
  task automatic txn(input logic rd, input logic wr, input logic st, input logic lt,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                     input int waits);
    logic        is_wr;
    logic        is_byte;
    logic        trap;
    logic        timed_out;
    int          acc;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    is_wr   = wr;
    is_byte = is_wr ? st : lt;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = !is_byte && (a % 4 != 0);
`else
    trap = 1'b0;
`endif
    timed_out = !trap && (waits >= int'(T));
    acc       = timed_out ? int'(T) : waits + 1;
    e_addr    = a - (a % 4);
    e_be      = (is_wr && st) ? 4'(1 << (a % 4)) : 4'hF;
    e_wd      = (is_wr && st) ? wd[7:0] * 32'h0101_0101 : wd;

    req_rd = rd; req_wr = wr; stype = st; ltype = lt;
    addr = a; wdata = wd; mem_rdata = rdat; mem_ready = 1'b0;
    @(negedge clk);
    if (trap) begin
      chk("trap_no_valid", 32'(mem_valid), 32'd0);
    end else begin
      for (int i = 0; i < acc; i++) begin
        mem_ready = !timed_out && (i == waits);
        chk("acc_valid", 32'(mem_valid), 32'd1);
        chk("acc_busy", 32'(busy), 32'd1);
        chk("acc_rvalid", 32'(rvalid), 32'd0);
        chk("acc_addr", mem_addr, e_addr);
        chk("acc_we", 32'(mem_we), 32'(is_wr));
        chk("acc_be", 32'(mem_be), 32'(e_be));
        if (is_wr) chk("acc_wdata", mem_wdata, e_wd);
        @(negedge clk);
      end
    end
    mem_ready = 1'b0;
    if (trap || timed_out) exp_rdata = 32'd0;
    else if (!is_wr) exp_rdata = lt ? ((rdat >> (8 * (a % 4))) & 32'hFF) : rdat;
    chk("resp_rvalid", 32'(rvalid), 32'd1);
    chk("resp_busy", 32'(busy), 32'd1);
    chk("resp_valid", 32'(mem_valid), 32'd0);
    chk("resp_err", 32'(err), 32'(trap || timed_out));
    chk("resp_rdata", rdata_out, exp_rdata);
    req_rd = 1'b0; req_wr = 1'b0;
    @(negedge clk);
    chk("idle_rvalid", 32'(rvalid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_err", 32'(err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        r_rd, r_wr, r_st, r_lt;
    logic [31:0] r_a, r_wd, r_rdat;
    int          r_w;

    rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; stype = 1'b0; ltype = 1'b0;
    addr = 32'd0; wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Directed cases
    txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);   // sw, no wait
    txn(1'b0, 1'b1, 1'b1, 1'b0, 32'h203, 32'h0000_00A5, 32'h0, 3);   // sb, 3 waits
    txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h302, 32'h0, 32'h1122_3344, 0);   // lbu lane 2
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 32'h1122_3344, 1);   // lw
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h304, 32'h0, 32'hCAFE_F00D, 16);  // timeout
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h308, 32'h0, 32'hCAFE_F00D, 15);  // ready on last cycle
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h101, 32'h0, 32'h5566_7788, 0);   // misaligned lw

    // Reset during ACCESS with both requests high
    req_rd = 1'b1; ltype = 1'b0; addr = 32'h400; mem_rdata = 32'h1234_5678; mem_ready = 1'b0;
    @(negedge clk);
    chk("mid_valid", 32'(mem_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1; req_wr = 1'b1; stype = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(mem_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_rdata", rdata_out, 32'd0);
    exp_rdata = 32'd0;
    rst = 1'b0;
    txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0BAD_F00D, 32'h9999_9999, 1);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      r_rd   = 1'($urandom % 2);
      r_wr   = r_rd ? 1'($urandom % 4 == 0) : 1'b1;
      r_st   = 1'($urandom % 2);
      r_lt   = 1'($urandom % 2);
      r_a    = $urandom;
      r_wd   = $urandom;
      r_rdat = $urandom;
      if ($urandom % 8 == 0) r_w = ($urandom % 2 == 0) ? 15 : 16 + int'($urandom % 3);
      else r_w = int'($urandom % 3);
      txn(r_rd, r_wr, r_st, r_lt, r_a, r_wd, r_rdat, r_w);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory port between the multicycle control FSM and the data RAM/bus; sits directly downstream of the Store/Load states.
- Accepts one word or byte access request, performs the bus handshake, and returns a registered, zero-extended read result to the datapath.
- Byte accesses (sb/lbu) use the same stype/ltype encoding as the control unit: stype 1 = sb, ltype 1 = lbu.
- Holds busy high so the control FSM can stall in Load/Store until the response is available.

Parameters:
- TIMEOUT_CYCLES, 16: cycles in ACCESS without mem_ready before the access is aborted; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_rd  input  1  read request (Load state).
- req_wr  input  1  write request (MemW).
- stype  input  1  0 = sw, 1 = sb.
- ltype  input  1  0 = lw, 1 = lbu.
- addr  input  32  byte address from the ALU result register.
- wdata  input  32  store data (rs2).
- busy  output  1  high while a request is in flight (ACCESS or RESP).
- rvalid  output  1  one-cycle pulse: rdata_out/err valid.
- rdata_out  output  32  registered load result.
- err  output  1  valid with rvalid; 1 = timeout or misaligned access.
- mem_valid  output  1  bus request.
- mem_we  output  1  bus write strobe.
- mem_addr  output  32  word-aligned address, {addr[31:2], 2'b00}.
- mem_be  output  4  byte enables.
- mem_wdata  output  32  bus write data.
- mem_ready  input  1  bus accept / read-data-valid.
- mem_rdata  input  32  bus read data.

Behaviour:
- Reset: state IDLE; busy, rvalid, err, mem_valid, mem_we = 0; mem_be = 0; mem_addr, mem_wdata, rdata_out = 0; timeout counter = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE -> ACCESS when req_rd or req_wr is sampled high.
  - On that edge, register: mem_addr, mem_we, mem_be, mem_wdata, and the low-address/ltype fields needed for read extraction.
  - If req_rd and req_wr are both high, the write wins and the read is dropped.
- ACCESS:
  - mem_valid = 1, busy = 1.
  - All bus outputs stay stable until mem_ready is sampled high.
- ACCESS -> RESP on the edge where mem_ready = 1.
  - Reads: capture rdata_out on this edge.
  - Writes: rdata_out is unchanged.
- RESP:
  - rvalid = 1 and busy = 1 for exactly one cycle; mem_valid = 0.
  - Always returns to IDLE on the next edge.
- Requests arriving while not in IDLE are ignored. The control unit holds its request until rvalid.
- Latency: request sampled at edge 0; mem_valid high during cycle 1; with mem_ready high in cycle 1, rvalid is high in cycle 2.
  - Minimum is 2 cycles request-to-rvalid.
  - Each wait cycle adds 1.
- Write lanes:
  - sw: mem_be = 4'hF, mem_wdata = wdata.
  - sb: mem_be = 4'b0001 << addr[1:0], mem_wdata = {4{wdata[7:0]}}.
- Read extraction:
  - lw: rdata_out = mem_rdata.
  - lbu: rdata_out = {24'b0, byte lane addr[1:0] of mem_rdata}.
  - Reads drive mem_be = 4'hF.
- Timeout:
  - The counter increments each ACCESS cycle while mem_ready = 0 and clears on entry to ACCESS.
  - When it reaches TIMEOUT_CYCLES, go to RESP with err = 1, rdata_out = 0, mem_valid low from that edge.
  - A mem_ready on the same edge as the timeout takes precedence: normal completion, err = 0.
- Reset mid-transaction: on the edge rst is sampled, all outputs return to reset values and mem_valid drops. No response is produced for the aborted access.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - A word access (lw/sw) with addr[1:0] != 0 goes IDLE -> RESP directly.
  - No bus cycle: mem_valid never asserts.
  - err = 1 with rvalid; rdata_out = 0; no write occurs.
- Not defined:
  - addr[1:0] is ignored for word accesses (forced alignment), the access proceeds normally, and err is only produced by timeout.

Test Plan:
- sw, addr=0x100, wdata=0xDEADBEEF, mem_ready tied high -> mem_valid in cycle 1, mem_we=1, mem_be=4'hF, mem_addr=0x100, mem_wdata=0xDEADBEEF; rvalid in cycle 2, err=0.
- sb, addr=0x203, wdata=0x000000A5, ready after 3 wait cycles -> mem_be=4'b1000, mem_addr=0x200, mem_wdata=0xA5A5A5A5; bus outputs stable while waiting; rvalid 5 cycles after the request.
- lbu, addr=0x302, mem_rdata=0x11223344 -> rdata_out=0x00000022; lw at the same address -> rdata_out=0x11223344.
- Read with mem_ready held low, TIMEOUT_CYCLES=16 -> mem_valid drops after 16 ACCESS cycles; rvalid=1, err=1, rdata_out=0. Repeat with ready rising on cycle 16 -> err=0 and data captured.
- rst asserted during ACCESS, then req_rd and req_wr both high -> reset values the next cycle with no rvalid; the subsequent access is a write (mem_we=1).
- MEM_MISALIGN_TRAP_EN, lw addr=0x101 -> no mem_valid; rvalid=1, err=1 in cycle 1. Without the macro -> mem_addr=0x100, normal read, err=0.
